// File: rtl/alu_share_arbiter_if.sv
// Bundles the two requester ports, the response port and the shared-ALU port of alu_share_arbiter.
// Modport slave is the arbiter's view; master is the view of the requesters, consumer and ALU.
interface alu_share_arbiter_if #(
    parameter int DP_WIDTH    = 32,
    parameter int ALUOP_WIDTH = 4
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [DP_WIDTH-1:0]    req0_a;
    logic [DP_WIDTH-1:0]    req0_b;
    logic [ALUOP_WIDTH-1:0] req0_op;
    logic [4:0]             req0_shamt;

    logic                   req1_valid;
    logic                   req1_ready;
    logic [DP_WIDTH-1:0]    req1_a;
    logic [DP_WIDTH-1:0]    req1_b;
    logic [ALUOP_WIDTH-1:0] req1_op;
    logic [4:0]             req1_shamt;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_id;
    logic [DP_WIDTH-1:0]    rsp_result;
    logic                   rsp_carry;
    logic                   rsp_ovf;

    logic [DP_WIDTH-1:0]    alu_a;
    logic [DP_WIDTH-1:0]    alu_b;
    logic [ALUOP_WIDTH-1:0] alu_op;
    logic [4:0]             alu_shamt;
    logic [DP_WIDTH-1:0]    alu_result;
    logic                   alu_carry;
    logic                   alu_ovf;

    logic                   busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_shamt,
        input  req1_valid, req1_a, req1_b, req1_op, req1_shamt,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf,
        input  rsp_ready,
        output alu_a, alu_b, alu_op, alu_shamt,
        input  alu_result, alu_carry, alu_ovf,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_shamt,
        output req1_valid, req1_a, req1_b, req1_op, req1_shamt,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf,
        output rsp_ready,
        input  alu_a, alu_b, alu_op, alu_shamt,
        output alu_result, alu_carry, alu_ovf,
        input  busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared, one-cycle-latency ALU: IDLE -> ISSUE -> WAIT -> RESP.
// Define ALU_ARB_RR_EN for round-robin grant; otherwise req0 has fixed priority.
module alu_share_arbiter #(
    parameter int DP_WIDTH    = 32,
    parameter int ALUOP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);
    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [N_REQ-1:0]       w_req_valid;
    logic [DP_WIDTH-1:0]    w_req_a     [N_REQ];
    logic [DP_WIDTH-1:0]    w_req_b     [N_REQ];
    logic [ALUOP_WIDTH-1:0] w_req_op    [N_REQ];
    logic [4:0]             w_req_shamt [N_REQ];
    logic [N_REQ-1:0]       w_ready;

    logic w_any_valid;
    logic w_accept;
    logic w_gnt_id;

    logic [DP_WIDTH-1:0]    r_op_a;
    logic [DP_WIDTH-1:0]    r_op_b;
    logic [ALUOP_WIDTH-1:0] r_op_code;
    logic [4:0]             r_op_shamt;
    logic                   r_op_id;

    logic                   r_rsp_id;
    logic [DP_WIDTH-1:0]    r_rsp_result;
    logic                   r_rsp_carry;
    logic                   r_rsp_ovf;

    assign w_req_valid    = {bus.req1_valid, bus.req0_valid};
    assign w_req_a[0]     = bus.req0_a;
    assign w_req_a[1]     = bus.req1_a;
    assign w_req_b[0]     = bus.req0_b;
    assign w_req_b[1]     = bus.req1_b;
    assign w_req_op[0]    = bus.req0_op;
    assign w_req_op[1]    = bus.req1_op;
    assign w_req_shamt[0] = bus.req0_shamt;
    assign w_req_shamt[1] = bus.req1_shamt;

    assign w_any_valid = |w_req_valid;

    // Ready is also gated by reset so no requester sees a handshake while the arbiter is held.
    assign w_accept = (r_state == S_IDLE) && w_any_valid && rst_n;

`ifdef ALU_ARB_RR_EN
    logic r_last_gnt;

    always_comb begin
        w_gnt_id = ~w_req_valid[0];
        if (&w_req_valid) begin
            w_gnt_id = ~r_last_gnt;
        end
    end

    // Starts as "req1 granted last" so req0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (w_accept) begin
            r_last_gnt <= w_gnt_id;
        end
    end
`else
    always_comb begin
        w_gnt_id = ~w_req_valid[0];
    end
`endif

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign w_ready[gi] = w_accept && (w_gnt_id == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = w_ready[0];
    assign bus.req1_ready = w_ready[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_RESP;
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand registers feed the ALU directly and only move on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_code  <= '0;
            r_op_shamt <= '0;
            r_op_id    <= 1'b0;
        end else if (w_accept) begin
            r_op_a     <= w_req_a[w_gnt_id];
            r_op_b     <= w_req_b[w_gnt_id];
            r_op_code  <= w_req_op[w_gnt_id];
            r_op_shamt <= w_req_shamt[w_gnt_id];
            r_op_id    <= w_gnt_id;
        end
    end

    // ALU output is valid during WAIT, one cycle after it sampled the operands in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else if (r_state == S_WAIT) begin
            r_rsp_id     <= r_op_id;
            r_rsp_result <= bus.alu_result;
            r_rsp_carry  <= bus.alu_carry;
            r_rsp_ovf    <= bus.alu_ovf;
        end
    end

    assign bus.alu_a      = r_op_a;
    assign bus.alu_b      = r_op_b;
    assign bus.alu_op     = r_op_code;
    assign bus.alu_shamt  = r_op_shamt;

    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_ovf    = r_rsp_ovf;

    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural one-cycle ALU; set ALU_ARB_RR_EN to match the DUT build.
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DP_WIDTH(DW), .ALUOP_WIDTH(OW)) bus ();

    alu_share_arbiter #(.DP_WIDTH(DW), .ALUOP_WIDTH(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic          id;
        logic [DW-1:0] res;
        logic          c;
        logic          v;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural ALU with registered outputs.
    logic [DW:0] alu_tmp;
    always @(posedge clk) begin
        case (bus.alu_op)
            OP_ADD: begin
                alu_tmp        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_result <= alu_tmp[DW-1:0];
                bus.alu_carry  <= alu_tmp[DW];
                bus.alu_ovf    <= (bus.alu_a[DW-1] == bus.alu_b[DW-1]) && (alu_tmp[DW-1] != bus.alu_a[DW-1]);
            end
            OP_SUB: begin
                alu_tmp        = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                bus.alu_result <= alu_tmp[DW-1:0];
                bus.alu_carry  <= alu_tmp[DW];
                bus.alu_ovf    <= (bus.alu_a[DW-1] != bus.alu_b[DW-1]) && (alu_tmp[DW-1] != bus.alu_a[DW-1]);
            end
            OP_AND: begin
                bus.alu_result <= bus.alu_a & bus.alu_b;
                bus.alu_carry  <= 1'b0;
                bus.alu_ovf    <= 1'b0;
            end
            OP_SLL: begin
                bus.alu_result <= bus.alu_a << bus.alu_shamt;
                bus.alu_carry  <= 1'b0;
                bus.alu_ovf    <= 1'b0;
            end
            default: begin
                bus.alu_result <= bus.alu_a ^ bus.alu_b;
                bus.alu_carry  <= 1'b0;
                bus.alu_ovf    <= 1'b0;
            end
        endcase
    end

    // Monitor: every completed response handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            $display("rsp id=%0d result=0x%08h carry=%0d ovf=%0d", bus.rsp_id, bus.rsp_result,
                     bus.rsp_carry, bus.rsp_ovf);
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 64'(sb_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_id",     64'(bus.rsp_id),     64'(e.id));
                check("rsp_result", 64'(bus.rsp_result), 64'(e.res));
                check("rsp_carry",  64'(bus.rsp_carry),  64'(e.c));
                check("rsp_ovf",    64'(bus.rsp_ovf),    64'(e.v));
            end
        end
    end

    function automatic logic rdy(input logic id);
        return id ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic drive_req(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [3:0] op, input logic [4:0] sh, input logic vld);
        if (id == 1'b0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_shamt = sh; bus.req0_valid = vld;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_shamt = sh; bus.req1_valid = vld;
        end
    endtask

    task automatic issue_op(input string name, input logic id, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [3:0] op, input logic [4:0] sh,
                            input logic [DW-1:0] er, input logic ec, input logic ev);
        int k;
        exp_t e;
        @(posedge clk); #1;
        drive_req(id, a, b, op, sh, 1'b1);
        k = 0;
        @(negedge clk);
        while (!rdy(id) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_ready"}, 64'(rdy(id)), 64'd1);
        check({name, "_other_ready"}, 64'(rdy(~id)), 64'd0);
        e.id = id; e.res = er; e.c = ec; e.v = ev;
        sb_q.push_back(e);
        $display("issue %s id=%0d a=0x%08h b=0x%08h op=%0d", name, id, a, b, op);
        @(posedge clk); #1;
        if (id == 1'b0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    endtask

    // Called from the first cycle after the accept edge; rsp_valid must rise on the third.
    task automatic wait_latency(input string name);
        int n;
        n = 1;
        @(negedge clk);
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'd3);
    endtask

    logic [3:0] cont_ids;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ALU_ARB_RR_EN
        cont_ids = 4'b1010;
`else
        cont_ids = 4'b0000;
`endif
        drive_req(1'b0, 32'h0, 32'h0, OP_ADD, 5'd0, 1'b1);
        drive_req(1'b1, 32'h0, 32'h0, OP_ADD, 5'd0, 1'b0);
        bus.rsp_ready = 1'b1;

        // Reset state, with a requester already valid.
        repeat (2) @(negedge clk);
        check("rst_busy",      64'(bus.busy),       64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid),  64'd0);
        check("rst_req0_rdy",  64'(bus.req0_ready), 64'd0);
        check("rst_rsp_res",   64'(bus.rsp_result), 64'd0);
        check("rst_alu_a",     64'(bus.alu_a),      64'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;

        // Single ops: plain add, then signed overflow from req1.
        issue_op("add", 1'b0, 32'd5, 32'd3, OP_ADD, 5'd0, 32'd8, 1'b0, 1'b0);
        wait_latency("add");
        issue_op("ovf", 1'b1, 32'h7FFF_FFFF, 32'd1, OP_ADD, 5'd0, 32'h8000_0000, 1'b0, 1'b1);
        wait_latency("ovf");

        // Backpressure: response held 10 cycles with req1 waiting.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        issue_op("bp", 1'b0, 32'hFFFF_FFFF, 32'd2, OP_ADD, 5'd0, 32'd1, 1'b1, 1'b0);
        wait_latency("bp");
        @(posedge clk); #1;
        drive_req(1'b1, 32'd1, 32'd0, OP_SLL, 5'd4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(bus.rsp_valid),  64'd1);
            check("bp_rsp_res",   64'(bus.rsp_result), 64'd1);
            check("bp_rsp_carry", 64'(bus.rsp_carry),  64'd1);
            check("bp_rsp_id",    64'(bus.rsp_id),     64'd0);
            check("bp_readies",   64'({bus.req1_ready, bus.req0_ready}), 64'd0);
            check("bp_busy",      64'(bus.busy),       64'd1);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_accept_on_hs", 64'(bus.req1_ready), 64'd0);
        @(negedge clk);
        check("bp_accept_next", 64'(bus.req1_ready), 64'd1);
        check("bp_idle_busy",   64'(bus.busy),       64'd0);
        sb_q.push_back('{id: 1'b1, res: 32'd16, c: 1'b0, v: 1'b0});
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_latency("sll");

        // Reset while the op sits in WAIT; it must vanish.
        @(posedge clk); #1;
        drive_req(1'b0, 32'h12, 32'h34, OP_ADD, 5'd0, 1'b1);
        @(negedge clk);
        check("wrst_accept", 64'(bus.req0_ready), 64'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_req(1'b1, 32'h55, 32'h0, OP_ADD, 5'd0, 1'b1);
        @(negedge clk);
        check("wrst_busy",      64'(bus.busy),       64'd0);
        check("wrst_rsp_valid", 64'(bus.rsp_valid),  64'd0);
        check("wrst_rsp_res",   64'(bus.rsp_result), 64'd0);
        check("wrst_rsp_id",    64'(bus.rsp_id),     64'd0);
        check("wrst_alu_a",     64'(bus.alu_a),      64'd0);
        check("wrst_alu_op",    64'(bus.alu_op),     64'd0);
        check("wrst_req1_rdy",  64'(bus.req1_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        issue_op("and", 1'b1, 32'h0000_F0F0, 32'h0000_FF00, OP_AND, 5'd0, 32'h0000_F000, 1'b0, 1'b0);
        wait_latency("and");

        // Contention: both valid for four grants.
        @(posedge clk); #1;
        drive_req(1'b0, 32'd10, 32'd20, OP_ADD, 5'd0, 1'b1);
        drive_req(1'b1, 32'd100, 32'd7, OP_SUB, 5'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = 0;
            @(negedge clk);
            while (!(bus.req0_ready || bus.req1_ready) && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("cont_gnt",     64'({bus.req1_ready, bus.req0_ready}), cont_ids[i] ? 64'd2 : 64'd1);
            if (cont_ids[i]) sb_q.push_back('{id: 1'b1, res: 32'd93, c: 1'b0, v: 1'b0});
            else             sb_q.push_back('{id: 1'b0, res: 32'd30, c: 1'b0, v: 1'b0});
            $display("issue cont%0d expected id=%0d", i, cont_ids[i]);
            @(posedge clk);
        end
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        repeat (8) @(negedge clk);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter DP_WIDTH, 32, datapath width of operands and result.
REQ-002 Parameter ALUOP_WIDTH, 4, width of ALU operation code.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 reqN_valid  in  1  requester N (N=0,1) holds a valid operation.
REQ-006 reqN_ready  out  1  requester N operation accepted this cycle.
REQ-007 reqN_a, reqN_b  in  DP_WIDTH  requester N operands.
REQ-008 reqN_op  in  ALUOP_WIDTH  requester N ALU operation code.
REQ-009 reqN_shamt  in  5  requester N shift amount.
REQ-010 rsp_valid  out  1  result held for the owning requester.
REQ-011 rsp_ready  in  1  owner consumes result.
REQ-012 rsp_id  out  1  index of requester that owns the result.
REQ-013 rsp_result  out  DP_WIDTH  captured ALU result.
REQ-014 rsp_carry, rsp_ovf  out  1  captured ALU carry and overflow flags.
REQ-015 alu_a, alu_b  out  DP_WIDTH  operands to the shared ALU.
REQ-016 alu_op  out  ALUOP_WIDTH; alu_shamt  out  5  operation and shift amount to the shared ALU.
REQ-017 alu_result  in  DP_WIDTH; alu_carry, alu_ovf  in  1  ALU outputs, registered inside the ALU (one-clock latency).
REQ-018 busy  out  1  arbiter state not IDLE.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; one state per clock except RESP, which holds.
REQ-020 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle, latch its a/b/op/shamt and id into operand registers, go to ISSUE; else stay IDLE.
REQ-021 reqN_ready SHALL be 0 in every state other than IDLE and for the non-granted requester; at most one ready high per cycle.
REQ-022 alu_a/alu_b/alu_op/alu_shamt SHALL be driven from the operand registers at all times and change only on an IDLE accept.
REQ-023 ISSUE: ALU samples operands at the cycle end; next state WAIT unconditionally.
REQ-024 WAIT: capture alu_result, alu_carry, alu_ovf into response registers at cycle end; next state RESP.
REQ-025 RESP: rsp_valid=1 with stable rsp_id/result/flags; on rsp_valid & rsp_ready go IDLE; otherwise hold indefinitely.
REQ-026 Latency: accept edge t0, rsp_valid high from cycle t0+3; minimum issue interval 4 cycles.
REQ-027 A new request SHALL NOT be accepted in the cycle the response handshake completes; acceptance resumes in the following IDLE cycle.
REQ-028 Requesters hold reqN_* stable until ready; arbiter does not sample operands outside the accept cycle.
REQ-029 Fixed priority (macro absent): req0 wins over req1 when both valid.
REQ-030 rsp_valid, busy, reqN_ready SHALL be pure decodes of state (and valid/grant for ready), no extra latency.

Reset
REQ-031 rst low SHALL asynchronously force state IDLE, rsp_valid=0, busy=0, reqN_ready=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_ovf=0, operand registers (hence alu_*) to 0.
REQ-032 Reset mid-operation (ISSUE/WAIT/RESP) SHALL discard the in-flight operation with no response produced.
REQ-033 Round-robin pointer (when compiled) SHALL reset to "last grant = 1" so req0 wins the first contention.

Configuration
REQ-034 Macro ALU_ARB_RR_EN defined: round-robin grant; on contention in IDLE the requester not granted last wins; pointer updates only on accept; single requester always wins regardless of pointer.
REQ-035 ALU_ARB_RR_EN undefined: fixed priority per REQ-029, no pointer register.

Verification
REQ-036 Single op: req0 a=5,b=3,op=Add,valid at t0 -> req0_ready=1 at t0, rsp_valid at t0+3, rsp_id=0, rsp_result=8, carry=0, ovf=0.
REQ-037 Overflow capture: req1 a=0x7FFFFFFF,b=1,op=Add -> rsp_id=1, rsp_result=0x80000000, rsp_ovf=1.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and payload stable, both reqN_ready=0, busy=1; rsp_ready=1 -> IDLE next cycle, new accept one cycle later.
REQ-039 Contention, both valid for 4 ops: without ALU_ARB_RR_EN -> rsp_id 0,0,0,0; with it -> rsp_id 0,1,0,1.
REQ-040 Reset in WAIT: rst low for one cycle -> state IDLE, rsp_valid never asserted for that op, all outputs 0; next request completes normally with latency 3.
